// File: rtl/adc_stream_responder.sv
// Command/response ADC front end: accepts a channel command, waits CONV_CYCLES, answers with one beat.
// Define ADC_RESP_RAMP_EN to replace the sample ports with internal per-channel ramp counters.
module adc_stream_responder #(
   parameter int unsigned CONV_CYCLES = 4
) (
   input  logic        sys_clk,
   input  logic        Reset_h,
   input  logic        command_valid,
   input  logic [4:0]  command_channel,
   input  logic        command_startofpacket,
   input  logic        command_endofpacket,
   output logic        command_ready,
   output logic        response_valid,
   output logic [4:0]  response_channel,
   output logic [11:0] response_data,
   output logic        response_startofpacket,
   output logic        response_endofpacket,
   input  logic [11:0] sample_ch1,
   input  logic [11:0] sample_ch2,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(CONV_CYCLES - 1);

   function automatic logic [11:0] select_sample(input logic [4:0]  ch,
                                                 input logic [11:0] s1,
                                                 input logic [11:0] s2);
      logic [11:0] r;
      case (ch)
         5'd1:    r = s1;
         5'd2:    r = s2;
         default: r = 12'h000;
      endcase
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [4:0]  ch_q, ch_d;
   logic        sop_q, sop_d;
   logic        eop_q, eop_d;
   logic [11:0] sample_q, sample_d;
   logic [4:0]  resp_ch_q, resp_ch_d;
   logic [11:0] resp_data_q, resp_data_d;
   logic        resp_sop_q, resp_sop_d;
   logic        resp_eop_q, resp_eop_d;
   logic [11:0] src1_s, src2_s;

`ifdef ADC_RESP_RAMP_EN
   logic [11:0] ramp1_q, ramp1_d;
   logic [11:0] ramp2_q, ramp2_d;
   logic        unused_samples_s;

   assign unused_samples_s = ^{sample_ch1, sample_ch2};
   assign src1_s = ramp1_q;
   assign src2_s = ramp2_q;
`else
   assign src1_s = sample_ch1;
   assign src2_s = sample_ch2;
`endif

   assign command_ready          = (state_q == IDLE);
   assign busy                   = (state_q != IDLE);
   assign response_valid         = (state_q == RESPOND);
   assign response_channel       = resp_ch_q;
   assign response_data          = resp_data_q;
   assign response_startofpacket = resp_sop_q;
   assign response_endofpacket   = resp_eop_q;

   // Next-state, capture and response-register update logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      sample_d    = sample_q;
      resp_ch_d   = resp_ch_q;
      resp_data_d = resp_data_q;
      resp_sop_d  = resp_sop_q;
      resp_eop_d  = resp_eop_q;
`ifdef ADC_RESP_RAMP_EN
      ramp1_d     = ramp1_q;
      ramp2_d     = ramp2_q;
`endif
      case (state_q)
         IDLE: begin
            if (command_valid) begin
               ch_d     = command_channel;
               sop_d    = command_startofpacket;
               eop_d    = command_endofpacket;
               sample_d = select_sample(command_channel, src1_s, src2_s);
               cnt_d    = 8'd0;
               state_d  = CONVERT;
            end else begin
               state_d  = IDLE;
            end
         end
         CONVERT: begin
            cnt_d = cnt_q + 8'd1;
            // Response fields move to the outputs only as RESPOND begins
            if (cnt_q == LAST_CNT) begin
               state_d     = RESPOND;
               resp_ch_d   = ch_q;
               resp_data_d = sample_q;
               resp_sop_d  = sop_q;
               resp_eop_d  = eop_q;
            end else begin
               state_d     = CONVERT;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
`ifdef ADC_RESP_RAMP_EN
            if (ch_q == 5'd1) begin
               ramp1_d = ramp1_q + 12'd1;
            end else if (ch_q == 5'd2) begin
               ramp2_d = ramp2_q + 12'd1;
            end else begin
               ramp1_d = ramp1_q;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge sys_clk or posedge Reset_h) begin
      if (Reset_h) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         ch_q        <= 5'd0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         sample_q    <= 12'h000;
         resp_ch_q   <= 5'd0;
         resp_data_q <= 12'h000;
         resp_sop_q  <= 1'b0;
         resp_eop_q  <= 1'b0;
`ifdef ADC_RESP_RAMP_EN
         ramp1_q     <= 12'h000;
         ramp2_q     <= 12'h800;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ch_q        <= ch_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         sample_q    <= sample_d;
         resp_ch_q   <= resp_ch_d;
         resp_data_q <= resp_data_d;
         resp_sop_q  <= resp_sop_d;
         resp_eop_q  <= resp_eop_d;
`ifdef ADC_RESP_RAMP_EN
         ramp1_q     <= ramp1_d;
         ramp2_q     <= ramp2_d;
`endif
      end
   end

endmodule

// File: tb/tb_adc_stream_responder.sv
// Self-checking bench for adc_stream_responder: directed vector table, hand-written corner
// sequences and randomized commands against a channel/ramp reference model.
module tb_adc_stream_responder;

   localparam int C = 4;

   logic        sys_clk = 1'b0;
   logic        Reset_h;
   logic        command_valid;
   logic [4:0]  command_channel;
   logic        command_startofpacket;
   logic        command_endofpacket;
   logic        command_ready;
   logic        response_valid;
   logic [4:0]  response_channel;
   logic [11:0] response_data;
   logic        response_startofpacket;
   logic        response_endofpacket;
   logic [11:0] sample_ch1;
   logic [11:0] sample_ch2;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: ramp values in ramp mode (unused otherwise)
   logic [11:0] r1_m = 12'h000;
   logic [11:0] r2_m = 12'h800;

   always #5 sys_clk = ~sys_clk;

   adc_stream_responder #(.CONV_CYCLES(C)) dut (
      .sys_clk                (sys_clk),
      .Reset_h                (Reset_h),
      .command_valid          (command_valid),
      .command_channel        (command_channel),
      .command_startofpacket  (command_startofpacket),
      .command_endofpacket    (command_endofpacket),
      .command_ready          (command_ready),
      .response_valid         (response_valid),
      .response_channel       (response_channel),
      .response_data          (response_data),
      .response_startofpacket (response_startofpacket),
      .response_endofpacket   (response_endofpacket),
      .sample_ch1             (sample_ch1),
      .sample_ch2             (sample_ch2),
      .busy                   (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [11:0] model_data(input logic [4:0] ch, input logic [11:0] s1,
                                              input logic [11:0] s2);
`ifdef ADC_RESP_RAMP_EN
      return (ch == 5'd1) ? r1_m : (ch == 5'd2) ? r2_m : 12'h000;
`else
      return (ch == 5'd1) ? s1 : (ch == 5'd2) ? s2 : 12'h000;
`endif
   endfunction

   task automatic model_advance(input logic [4:0] ch);
`ifdef ADC_RESP_RAMP_EN
      if (ch == 5'd1) r1_m = r1_m + 12'd1;
      if (ch == 5'd2) r2_m = r2_m + 12'd1;
`endif
   endtask

   // Present a command and hold valid until the edge that accepts it
   task automatic issue(input logic [4:0] ch, input logic sop, input logic eop);
      logic rdy;
      bit   acc;
      acc = 1'b0;
      command_channel       = ch;
      command_startofpacket = sop;
      command_endofpacket   = eop;
      command_valid         = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         rdy = command_ready;
         tick();
         acc = rdy;
      end
      command_valid = 1'b0;
      chk("accept_within_bound", 32'(acc), 32'd1);
   endtask

   // One full transaction; inputs are disturbed right after acceptance
   task automatic run_cmd(input string tag, input logic [4:0] ch, input logic sop, input logic eop,
                          input logic [11:0] s1, input logic [11:0] s2, input logic [11:0] exp_data);
      int lat;
      sample_ch1 = s1;
      sample_ch2 = s2;
      issue(ch, sop, eop);
      sample_ch1 = ~s1;
      sample_ch2 = ~s2;
      command_channel       = ~ch;
      command_startofpacket = ~sop;
      command_endofpacket   = ~eop;
      lat = -1;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         chk({tag, "_ready_low_busy"}, {command_ready, busy}, 2'b01);
         if (response_valid) lat = n;
      end
      // The accepting edge is the first of CONV_CYCLES+1 edges; the beat shows after the last
      chk({tag, "_latency"}, 32'(lat), 32'(C));
      chk({tag, "_channel"}, response_channel, ch);
      chk({tag, "_data"}, response_data, exp_data);
      chk({tag, "_sop_eop"}, {response_startofpacket, response_endofpacket}, {sop, eop});
      tick();
      chk({tag, "_single_pulse"}, {response_valid, command_ready, busy}, 3'b010);
      chk({tag, "_data_held"}, {response_channel, response_data}, {ch, exp_data});
   endtask

   task automatic run_model(input string tag, input logic [4:0] ch, input logic sop, input logic eop,
                            input logic [11:0] s1, input logic [11:0] s2);
      run_cmd(tag, ch, sop, eop, s1, s2, model_data(ch, s1, s2));
      model_advance(ch);
   endtask

   typedef struct {
      logic [4:0]  ch;
      logic        sop;
      logic        eop;
      logic [11:0] s1;
      logic [11:0] s2;
      logic [11:0] exp_data;
   } vec_t;

   initial begin
      vec_t        vecs[8];
      logic [4:0]  exp_q[$];
      logic [4:0]  e;
      logic [4:0]  rch;
      logic        rdy;
      int          last_acc;
      int          pulses;

      Reset_h = 1'b1;
      command_valid = 1'b0;
      command_channel = 5'd0;
      command_startofpacket = 1'b0;
      command_endofpacket = 1'b0;
      sample_ch1 = 12'h000;
      sample_ch2 = 12'h000;

      repeat (3) tick();
      chk("reset_ready_busy_valid", {command_ready, busy, response_valid}, 3'b100);
      chk("reset_resp_fields", {response_channel, response_data, response_startofpacket,
          response_endofpacket}, 19'd0);
      Reset_h = 1'b0;

`ifdef ADC_RESP_RAMP_EN
      for (int i = 0; i < 3; i++) run_cmd("ramp2_seq", 5'd2, 1'b0, 1'b0, 12'h555, 12'h555, 12'h800 + 12'(i));
      r2_m = 12'h803;
      for (int i = 0; i < 4095; i++) run_model("ramp1_preset", 5'd1, 1'b0, 1'b0, 12'h0, 12'h0);
      run_cmd("ramp1_top", 5'd1, 1'b1, 1'b0, 12'h123, 12'h456, 12'hFFF);
      run_cmd("ramp1_wrap", 5'd1, 1'b0, 1'b1, 12'h123, 12'h456, 12'h000);
      r1_m = 12'h001;
`else
      vecs[0] = '{5'd1,  1'b0, 1'b0, 12'hABC, 12'h123, 12'hABC};
      vecs[1] = '{5'd2,  1'b1, 1'b0, 12'hABC, 12'h123, 12'h123};
      vecs[2] = '{5'd5,  1'b1, 1'b1, 12'hABC, 12'h123, 12'h000};
      vecs[3] = '{5'd0,  1'b0, 1'b1, 12'hFFF, 12'hFFF, 12'h000};
      vecs[4] = '{5'd31, 1'b1, 1'b1, 12'h555, 12'hAAA, 12'h000};
      vecs[5] = '{5'd2,  1'b0, 1'b1, 12'h000, 12'hFFF, 12'hFFF};
      vecs[6] = '{5'd1,  1'b1, 1'b1, 12'hFFF, 12'h000, 12'hFFF};
      vecs[7] = '{5'd3,  1'b0, 1'b0, 12'h111, 12'h222, 12'h000};
      for (int i = 0; i < 8; i++)
         run_cmd($sformatf("vec%0d", i), vecs[i].ch, vecs[i].sop, vecs[i].eop,
                 vecs[i].s1, vecs[i].s2, vecs[i].exp_data);

      // Sample change one cycle after acceptance must not leak into the answer
      sample_ch1 = 12'h100;
      issue(5'd1, 1'b0, 1'b0);
      sample_ch1 = 12'h200;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (response_valid) begin
            pulses++;
            chk("late_sample_change_data", response_data, 12'h100);
         end
      end
      chk("late_sample_change_pulses", 32'(pulses), 32'd1);

      // Valid held continuously with alternating channels
      sample_ch1 = 12'hABC;
      sample_ch2 = 12'h123;
      command_channel = 5'd1;
      command_valid = 1'b1;
      last_acc = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         rdy = command_ready;
         chk("stream_ready_vs_busy", {rdy, busy}, {~busy, busy});
         tick();
         if (rdy) begin
            if (last_acc >= 0) chk("stream_accept_gap", 32'(cyc - last_acc), 32'(C + 2));
            last_acc = cyc;
            exp_q.push_back(command_channel);
            command_channel = (command_channel == 5'd1) ? 5'd2 : 5'd1;
         end
         if (response_valid) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("stream_channel", response_channel, e);
               chk("stream_data", response_data, (e == 5'd1) ? 12'hABC : 12'h123);
            end else begin
               chk("stream_spurious_response", 32'd1, 32'd0);
            end
         end
      end
      command_valid = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick();
         if (response_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stream_drain_channel", response_channel, e);
         end
      end
      chk("stream_all_answered", 32'(exp_q.size()), 32'd0);
`endif

      // Randomized commands against the model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       rch = 5'd1;
            1:       rch = 5'd2;
            default: rch = 5'($urandom_range(0, 31));
         endcase
         run_model("rand", rch, 1'($urandom), 1'($urandom), 12'($urandom), 12'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      // Reset two cycles after acceptance drops the pending response
      sample_ch1 = 12'h777;
      issue(5'd1, 1'b1, 1'b1);
      repeat (2) tick();
      Reset_h = 1'b1;
      #1;
      chk("midreset_ready_busy_valid", {command_ready, busy, response_valid}, 3'b100);
      chk("midreset_resp_data", response_data, 12'h000);
      tick();
      Reset_h = 1'b0;
      r1_m = 12'h000;
      r2_m = 12'h800;
      pulses = 0;
      for (int n = 0; n < 12; n++) begin
         tick();
         if (response_valid) pulses++;
      end
      chk("midreset_no_pulse", 32'(pulses), 32'd0);

      // First edge after release accepts a command
      Reset_h = 1'b1;
      tick();
      Reset_h = 1'b0;
      run_model("post_reset", 5'd2, 1'b1, 1'b0, 12'h0F0, 12'h3C3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
